// File: rtl/s_term_ihp_sram_arbiter.sv
// Round-robin arbiter sharing the single port of the S_term IHP SRAM macro between two fabric ports.
// Define IHP_SRAM_ARB_RDREG_EN to register rdata_o/rvalid_o (read latency N+3 instead of N+2).
module s_term_ihp_sram_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    localparam int BURST_W  = $clog2(MAX_BURST + 1)
) (
    input  logic                  UserCLK,
    input  logic                  resetn,
    input  logic [1:0]            req_i,
    input  logic [1:0]            we_i,
    input  logic [2*ADDR_W-1:0]   addr_i,
    input  logic [2*DATA_W-1:0]   wdata_i,
    input  logic [2*DATA_W-1:0]   bm_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rvalid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  sram_men_o,
    output logic                  sram_wen_o,
    output logic                  sram_ren_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [DATA_W-1:0]     sram_din_o,
    output logic [DATA_W-1:0]     sram_bm_o,
    input  logic [DATA_W-1:0]     sram_dout_i,
    output logic [1:0]            dbg_state_o,
    output logic                  dbg_rr_ptr_o,
    output logic [BURST_W-1:0]    dbg_burst_cnt_o
);

    // Handshake: a port raises req_i[k] with its we/addr/wdata/bm and holds them
    // until gnt_o[k] is seen; the access is accepted on the rising edge where both are high.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    state_e               state_q, state_d;
    logic                 rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [1:0]           gnt;
    logic                 own;
    logic                 oth;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gnt         = 2'b00;
        own         = (state_q == OWN1);
        oth         = ~own;
        case (state_q)
            IDLE: begin
                if (req_i[0] && req_i[1]) begin
                    gnt[rr_ptr_q] = 1'b1;
                    state_d       = rr_ptr_q ? OWN1 : OWN0;
                    burst_cnt_d   = BURST_ONE;
                end else if (req_i[0]) begin
                    gnt[0]      = 1'b1;
                    state_d     = OWN0;
                    burst_cnt_d = BURST_ONE;
                end else if (req_i[1]) begin
                    gnt[1]      = 1'b1;
                    state_d     = OWN1;
                    burst_cnt_d = BURST_ONE;
                end
            end
            OWN0, OWN1: begin
                if (req_i[own]) begin
                    if (req_i[oth] && burst_cnt_q == BURST_MAX) begin
                        gnt[oth]    = 1'b1;
                        state_d     = oth ? OWN1 : OWN0;
                        burst_cnt_d = BURST_ONE;
                        rr_ptr_d    = oth;
                    end else begin
                        // Without contention the counter just saturates, so a late
                        // request from the other port waits at most one more grant.
                        gnt[own] = 1'b1;
                        if (burst_cnt_q != BURST_MAX) begin
                            burst_cnt_d = burst_cnt_q + BURST_ONE;
                        end
                    end
                end else if (req_i[oth]) begin
                    gnt[oth]    = 1'b1;
                    state_d     = oth ? OWN1 : OWN0;
                    burst_cnt_d = BURST_ONE;
                    rr_ptr_d    = oth;
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                    rr_ptr_d    = oth;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    assign gnt_o           = gnt;
    assign dbg_state_o     = state_q;
    assign dbg_rr_ptr_o    = rr_ptr_q;
    assign dbg_burst_cnt_o = burst_cnt_q;

    // Macro-side request register: zero whenever nothing was granted.
    logic                 sel;
    logic                 any_gnt;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [DATA_W-1:0]    sel_bm;

    logic                 men_q, men_d;
    logic                 wen_q, wen_d;
    logic                 ren_q, ren_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    din_q, din_d;
    logic [DATA_W-1:0]    bm_q, bm_d;
    logic                 port1_q, port1_d;
    logic                 rd2_q, rd2_d;
    logic                 port2_q, port2_d;

    always_comb begin
        sel       = gnt[1];
        any_gnt   = |gnt;
        sel_we    = sel ? we_i[1] : we_i[0];
        sel_addr  = sel ? addr_i[ADDR_W +: ADDR_W]  : addr_i[0 +: ADDR_W];
        sel_wdata = sel ? wdata_i[DATA_W +: DATA_W] : wdata_i[0 +: DATA_W];
        sel_bm    = sel ? bm_i[DATA_W +: DATA_W]    : bm_i[0 +: DATA_W];

        men_d   = any_gnt;
        wen_d   = any_gnt & sel_we;
        ren_d   = any_gnt & ~sel_we;
        addr_d  = any_gnt ? sel_addr : '0;
        din_d   = (any_gnt && sel_we) ? sel_wdata : '0;
        bm_d    = (any_gnt && sel_we) ? sel_bm    : '0;
        port1_d = sel;

        // Second stage lines up with the cycle the macro presents dout.
        rd2_d   = ren_q;
        port2_d = port1_q;
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
            men_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            bm_q        <= '0;
            port1_q     <= 1'b0;
            rd2_q       <= 1'b0;
            port2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            men_q       <= men_d;
            wen_q       <= wen_d;
            ren_q       <= ren_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            bm_q        <= bm_d;
            port1_q     <= port1_d;
            rd2_q       <= rd2_d;
            port2_q     <= port2_d;
        end
    end

    assign sram_men_o  = men_q;
    assign sram_wen_o  = wen_q;
    assign sram_ren_o  = ren_q;
    assign sram_addr_o = addr_q;
    assign sram_din_o  = din_q;
    assign sram_bm_o   = bm_q;

    logic [1:0]           rsp_valid;
    logic [DATA_W-1:0]    rsp_data;

    always_comb begin
        rsp_valid = 2'b00;
        rsp_data  = '0;
        if (rd2_q) begin
            rsp_valid = port2_q ? 2'b10 : 2'b01;
            rsp_data  = sram_dout_i;
        end
    end

`ifdef IHP_SRAM_ARB_RDREG_EN
    logic [1:0]           rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    always_comb begin
        rvalid_d = rsp_valid;
        rdata_d  = rsp_data;
    end

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            rvalid_q <= 2'b00;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
`else
    assign rvalid_o = rsp_valid;
    assign rdata_o  = rsp_data;
`endif

endmodule

// File: tb/tb_s_term_ihp_sram_arbiter.sv
// Bench for s_term_ihp_sram_arbiter: behavioural macro, shadow-memory scoreboard, directed and random traffic.
module tb_s_term_ihp_sram_arbiter;

    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int BURST_W   = $clog2(MAX_BURST + 1);
`ifdef IHP_SRAM_ARB_RDREG_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 2;
`endif

    // clock / reset
    logic UserCLK = 1'b0;
    logic resetn  = 1'b1;
    always #5 UserCLK = ~UserCLK;

    logic                  req_p   [2];
    logic                  we_p    [2];
    logic [ADDR_W-1:0]     addr_p  [2];
    logic [DATA_W-1:0]     wdata_p [2];
    logic [DATA_W-1:0]     bm_p    [2];

    logic [1:0]            req_i, we_i;
    logic [2*ADDR_W-1:0]   addr_i;
    logic [2*DATA_W-1:0]   wdata_i, bm_i;
    logic [1:0]            gnt_o, rvalid_o;
    logic [DATA_W-1:0]     rdata_o;
    logic                  sram_men_o, sram_wen_o, sram_ren_o;
    logic [ADDR_W-1:0]     sram_addr_o;
    logic [DATA_W-1:0]     sram_din_o, sram_bm_o;
    logic [DATA_W-1:0]     sram_dout_i;
    logic [1:0]            dbg_state_o;
    logic                  dbg_rr_ptr_o;
    logic [BURST_W-1:0]    dbg_burst_cnt_o;

    assign req_i   = {req_p[1], req_p[0]};
    assign we_i    = {we_p[1], we_p[0]};
    assign addr_i  = {addr_p[1], addr_p[0]};
    assign wdata_i = {wdata_p[1], wdata_p[0]};
    assign bm_i    = {bm_p[1], bm_p[0]};

    s_term_ihp_sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .UserCLK(UserCLK), .resetn(resetn),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .bm_i(bm_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .sram_men_o(sram_men_o), .sram_wen_o(sram_wen_o), .sram_ren_o(sram_ren_o),
        .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_bm_o(sram_bm_o),
        .sram_dout_i(sram_dout_i),
        .dbg_state_o(dbg_state_o), .dbg_rr_ptr_o(dbg_rr_ptr_o), .dbg_burst_cnt_o(dbg_burst_cnt_o)
    );

    // behavioural macro: write with bit mask, read data valid the following cycle
    logic [DATA_W-1:0] mem    [512];
    logic [DATA_W-1:0] shadow [512];

    always @(posedge UserCLK) begin
        if (sram_men_o) begin
            if (sram_wen_o) mem[sram_addr_o] <= (mem[sram_addr_o] & ~sram_bm_o) | (sram_din_o & sram_bm_o);
            if (sram_ren_o) sram_dout_i <= mem[sram_addr_o];
        end
    end

    // checking
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard
    logic [DATA_W-1:0] exp_q     [2][$];
    int                exp_cyc_q [2][$];
    logic [DATA_W-1:0] last_rdata [2];
    int                cyc = 0;
    logic              prev_any, prev_we, mon_sel;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata, prev_bm;

    always @(negedge UserCLK) begin
        cyc++;
        if (!resetn) begin
            for (int p = 0; p < 2; p++) begin
                exp_q[p].delete();
                exp_cyc_q[p].delete();
            end
            prev_any = 1'b0;
        end else begin
            check_eq("sram_men", sram_men_o, prev_any);
            check_eq("sram_wen", sram_wen_o, prev_any & prev_we);
            check_eq("sram_ren", sram_ren_o, prev_any & ~prev_we);
            check_eq("sram_addr", sram_addr_o, prev_any ? prev_addr : '0);
            check_eq("sram_din", sram_din_o, (prev_any && prev_we) ? prev_wdata : '0);
            check_eq("sram_bm", sram_bm_o, (prev_any && prev_we) ? prev_bm : '0);
            check_eq("gnt_no_req", gnt_o & ~req_i, 2'b00);
            check_eq("gnt_onehot", gnt_o == 2'b11, 1'b0);

            for (int p = 0; p < 2; p++) begin
                if (exp_q[p].size() != 0 && exp_cyc_q[p][0] == cyc) begin
                    check_eq("rvalid", rvalid_o[p], 1'b1);
                    check_eq("rdata", rdata_o, exp_q[p][0]);
                    last_rdata[p] = rdata_o;
                    void'(exp_q[p].pop_front());
                    void'(exp_cyc_q[p].pop_front());
                end else begin
                    check_eq("rvalid_idle", rvalid_o[p], 1'b0);
                end
            end
            if (rvalid_o == 2'b00) check_eq("rdata_idle", rdata_o, '0);

            mon_sel    = gnt_o[1];
            prev_any   = |gnt_o;
            prev_we    = we_i[mon_sel];
            prev_addr  = addr_p[mon_sel];
            prev_wdata = wdata_p[mon_sel];
            prev_bm    = bm_p[mon_sel];
            if (prev_any) begin
                if (prev_we) begin
                    shadow[prev_addr] = (shadow[prev_addr] & ~prev_bm) | (prev_wdata & prev_bm);
                end else begin
                    exp_q[mon_sel].push_back(shadow[prev_addr]);
                    exp_cyc_q[mon_sel].push_back(cyc + RD_LAT);
                end
            end
        end
    end

    // driver tasks
    task automatic issue(input int p, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
        int waited = 0;
        req_p[p] = 1'b1; we_p[p] = we; addr_p[p] = a; wdata_p[p] = d; bm_p[p] = m;
        do begin
            @(negedge UserCLK);
            waited++;
        end while (!gnt_o[p] && waited < 40);
        check_eq("gnt_wait", gnt_o[p], 1'b1);
        @(posedge UserCLK); #1;
        req_p[p] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < 20) begin
            @(negedge UserCLK);
            n++;
        end
        check_eq("drain", exp_q[0].size() + exp_q[1].size(), 0);
        @(posedge UserCLK); #1;
    endtask

    task automatic do_reset();
        req_p[0] = 1'b0; req_p[1] = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge UserCLK);
        #1 resetn = 1'b1;
    endtask

    task automatic rand_traffic(input int p, input int n);
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d, m;
        for (int i = 0; i < n; i++) begin
            w = 1'($urandom_range(0, 1));
            a = ADDR_W'($urandom_range(0, 15));
            d = $urandom;
            m = ($urandom_range(0, 1) == 1) ? '1 : DATA_W'($urandom);
            issue(p, w, a, d, m);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge UserCLK); #1;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            req_p[p] = 1'b0; we_p[p] = 1'b0; addr_p[p] = '0; wdata_p[p] = '0; bm_p[p] = '0;
            last_rdata[p] = '0;
        end
        sram_dout_i = '0;
        #2 resetn = 1'b0;
        repeat (3) @(posedge UserCLK);
        #1 resetn = 1'b1;

        // reset / idle
        repeat (2) @(negedge UserCLK);
        check_eq("rst_gnt", gnt_o, 2'b00);
        check_eq("rst_rvalid", rvalid_o, 2'b00);
        check_eq("rst_rdata", rdata_o, '0);
        check_eq("rst_men", sram_men_o, 1'b0);
        check_eq("rst_addr", sram_addr_o, '0);
        check_eq("rst_state", dbg_state_o, 2'd0);
        check_eq("rst_burst", dbg_burst_cnt_o, '0);
        check_eq("rst_rr", dbg_rr_ptr_o, 1'b0);
        @(posedge UserCLK); #1;

        // single write then read on port 0
        issue(0, 1'b1, 9'h010, 32'hA5A5_0001, '1);
        issue(0, 1'b0, 9'h010, '0, '0);
        drain();
        check_eq("single_rd", last_rdata[0], 32'hA5A5_0001);

        // bit mask on port 1
        issue(1, 1'b1, 9'h055, 32'hFFFF_FFFF, '1);
        issue(1, 1'b1, 9'h055, 32'h0000_0000, 32'h0000_FFFF);
        issue(1, 1'b0, 9'h055, '0, '0);
        drain();
        check_eq("bm_rd", last_rdata[1], 32'hFFFF_0000);

        // burst fairness from a fresh rr_ptr=0
        do_reset();
        we_p[0] = 1'b0; we_p[1] = 1'b0;
        req_p[0] = 1'b1; req_p[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge UserCLK);
            check_eq("fair_gnt", gnt_o, (((i / MAX_BURST) % 2) == 1) ? 2'b10 : 2'b01);
            @(posedge UserCLK); #1;
            addr_p[0] = ADDR_W'($urandom_range(0, 31));
            addr_p[1] = ADDR_W'($urandom_range(0, 31));
        end
        req_p[0] = 1'b0; req_p[1] = 1'b0;
        drain();

        // hand-off: port 0 drops after two grants
        do_reset();
        we_p[0] = 1'b0; we_p[1] = 1'b0;
        req_p[0] = 1'b1; req_p[1] = 1'b1;
        @(negedge UserCLK); check_eq("ho_gnt0", gnt_o, 2'b01);
        @(posedge UserCLK); #1;
        @(negedge UserCLK); check_eq("ho_gnt1", gnt_o, 2'b01);
        @(posedge UserCLK); #1; req_p[0] = 1'b0;
        @(negedge UserCLK); check_eq("ho_gnt2", gnt_o, 2'b10);
        @(posedge UserCLK); #1; req_p[1] = 1'b0;
        @(negedge UserCLK);
        check_eq("ho_burst", dbg_burst_cnt_o, BURST_W'(1));
        check_eq("ho_state", dbg_state_o, 2'd2);
        check_eq("ho_rr", dbg_rr_ptr_o, 1'b1);
        @(posedge UserCLK); #1;
        drain();

        // reset while a read is on the macro
        issue(0, 1'b0, 9'h010, '0, '0);
        check_eq("rr_ren_pre", sram_ren_o, 1'b1);
        resetn = 1'b0;
        #1;
        check_eq("rr_ren_async", sram_ren_o, 1'b0);
        check_eq("rr_men_async", sram_men_o, 1'b0);
        check_eq("rr_addr_async", sram_addr_o, '0);
        repeat (2) @(posedge UserCLK);
        #1 resetn = 1'b1;
        repeat (6) @(posedge UserCLK);
        #1;

        // random interleaved traffic incl. same-address write/read
        fork
            rand_traffic(0, 40);
            rand_traffic(1, 40);
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
